// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: generates word-aligned fetch addresses, tags the
// returning memory data with its PC, and presents a registered IF/ID bundle.
// The memory answers one cycle after the address is presented, so a
// one-entry hold buffer keeps the returning word safe while decode is
// stalled. Redirects flush everything in flight.
//
// Handshake: there is no valid/ready pair here. stall freezes the stage
// for one edge. redirect_valid flushes the stage on one edge and wins over
// stall. id_valid qualifies id_pc/id_instruction, which are don't-care
// whenever id_valid is 0.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic [31:0] imem_instruction,
    output logic [31:0] imem_address,
    output logic [31:0] id_pc,
    output logic [31:0] id_instruction,
    output logic        id_valid
);

    // RUN: the hold buffer is empty. HOLD: the buffer keeps the word that
    // was returning when the stall began.
    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  req_pc;
    logic         req_valid;
    logic [31:0]  hold_instr;

    // The fetch address is the PC register itself, so it is registered.
    assign imem_address = pc;

    // Fetch pipeline. Priority on each edge: reset, redirect, stall, advance.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc             <= RESET_PC;
            req_pc         <= 32'h0000_0000;
            req_valid      <= 1'b0;
            hold_instr     <= 32'h0000_0000;
            state          <= RUN;
            id_pc          <= 32'h0000_0000;
            id_instruction <= 32'h0000_0000;
            id_valid       <= 1'b0;
        end else if (redirect_valid) begin
            // The read in flight and any buffered word belong to the old
            // path. id_pc/id_instruction are left alone because id_valid
            // already marks them as a bubble.
            pc        <= redirect_target & ~32'h0000_0003;
            req_valid <= 1'b0;
            state     <= RUN;
            id_valid  <= 1'b0;
        end else if (stall) begin
            // Capture the returning word only on the first stalled edge.
            // Later edges see a re-read of pc, which is not this word.
            if (state == RUN) begin
                hold_instr <= imem_instruction;
                state      <= HOLD;
            end
        end else begin
            id_pc          <= req_pc;
            id_instruction <= (state == HOLD) ? hold_instr : imem_instruction;
            id_valid       <= req_valid;
            req_pc         <= pc;
            req_valid      <= 1'b1;
            pc             <= pc + 32'd4;
            state          <= RUN;
        end
    end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Fetch stage of the pipelined RISC-V core, directly upstream of the instruction memory. It generates the word-aligned fetch address and tags each returned instruction with its PC and a valid bit. It absorbs the memory's one-cycle synchronous read latency with a one-entry hold buffer, so stalls never lose or duplicate an instruction. It also presents a registered IF/ID bundle to decode and honours stall and redirect (branch/jump flush) requests from later stages.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; must be word aligned.
- clk  in  1  rising-edge clock, shared with instruction memory.
- resetn  in  1  synchronous, active-low reset.
- stall  in  1  hazard unit freeze request; holds the PC and the IF/ID bundle.
- redirect_valid  in  1  branch/jump taken; flushes in-flight fetches.
- redirect_target  in  32  new PC; bits [1:0] forced to 0 internally.
- imem_instruction  in  32  registered read data from instruction memory (data of the address presented one cycle earlier).
- imem_address  out  32  fetch address driven to instruction memory (= pc register).
- id_pc  out  32  PC of instruction in IF/ID.
- id_instruction  out  32  instruction in IF/ID.
- id_valid  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- State registers:
  - pc (drives imem_address)
  - req_pc/req_valid: tag of the read currently returning on imem_instruction
  - hold_instr/held: skid buffer
  - id_pc/id_instruction/id_valid
- Priority each edge: resetn low > redirect_valid > stall > normal advance.
- Reset:
  - pc = RESET_PC; req_valid = 0; held = 0; hold_instr = 0.
  - id_pc = 0; id_instruction = 0; id_valid = 0.
- Normal advance:
  - id_pc <= req_pc.
  - id_instruction <= held ? hold_instr : imem_instruction.
  - id_valid <= req_valid.
  - req_pc <= pc; req_valid <= 1; pc <= pc + 4; held <= 0.
- Stall:
  - pc, req_pc, req_valid and the id_* registers hold.
  - If held = 0: hold_instr <= imem_instruction; held <= 1.
  - If held = 1: hold_instr is unchanged. Memory output during the stall (a re-read of pc) is ignored.
- Redirect:
  - pc <= {redirect_target[31:2], 2'b00}.
  - req_valid <= 0; held <= 0; id_valid <= 0.
  - id_pc and id_instruction may take any value; decode must gate on id_valid.
  - Redirect overrides a simultaneous stall and discards hold_instr.
- PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. The stage does no bounds checking against memory size.
- States, encoded as held ∈ {0,1}:
  - RUN → HOLD on stall.
  - HOLD → HOLD while stall.
  - HOLD → RUN on stall release (entry drained to IF/ID) or on redirect (entry dropped).

## Timing
- Fetch latency: address issued at edge N reaches id_* at edge N+2 (memory register plus IF/ID register).
- Steady state: one instruction per cycle; id_pc increments by 4 each cycle.
- After reset deassertion: first valid id_* (pc = RESET_PC) appears two edges later.
- Redirect at edge N:
  - id_valid = 0 after edges N and N+1.
  - id_pc = target with id_valid = 1 after edge N+2 (two-bubble penalty).
- Stall asserted for K cycles:
  - id_* frozen for K edges.
  - At the release edge, id_* takes the buffered instruction.
  - No gap or duplicate in the id_pc sequence.
- Stall during the reset-recovery bubbles (req_valid = 0) buffers a don't-care value with valid 0; no spurious id_valid.
- Reset mid-stall or mid-redirect: all state returns to reset values at that edge; the hold buffer is cleared.
- All outputs are registered; no combinational path from stall or redirect_* to any output.

## Test plan
- Reset, then run with memory holding 0x00000000@0, 0x00F00093@4 → id_valid goes 1 two edges after release; id_pc/id_instruction = 0/0x00000000, then 4/0x00F00093; imem_address advances 0, 4, 8, 12.
- Stall for 3 cycles while id_pc = 4 → id_* frozen at 4/0x00F00093 for 3 edges; next id_pc = 8 with the correct word; pc steps never skip or repeat.
- Redirect to 0x14 with memory 0x00C09183@20, 0x0030AA23@36 → exactly two bubbles (id_valid = 0); then id_pc 0x14/0x00C09183, 0x18, …; then redirect to 0x26 → issues 0x24, id_instruction 0x0030AA23.
- Redirect asserted together with stall → redirect wins; held cleared; two bubbles follow; the stale buffered word never reaches id_*.
- resetn pulled low for one cycle mid-stream with held = 1 → next edge: imem_address = RESET_PC, id_valid = 0, held = 0; restart identical to the first scenario.
- Redirect to 0xFFFFFFFC → id_pc 0xFFFFFFFC, then 0x00000000 (wrap); redirect target 0x17 → imem_address 0x14.
